// File: rtl/ir_nec_transmit.sv
// NEC infrared transmitter: serialises a 32-bit word LSB first into the NEC
// mark/space train and gates the mark envelope with a 38 kHz carrier.
module ir_nec_transmit #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 64
) (
  input  logic        master_clk,
  input  logic        resetn,
  input  logic        send,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        ir_envelope,
  output logic        ir_tx
);

  // state      | meaning
  // IDLE       | waiting for an accepted send
  // LEAD_MARK  | 16-unit leader mark
  // LEAD_SPACE | 8-unit leader space
  // BIT_MARK   | 1-unit mark opening each data bit
  // BIT_SPACE  | 1 unit for a 0, 3 units for a 1
  // STOP_MARK  | 1-unit trailing mark
  // GAP        | GAP_UNITS idle units before the next frame
  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  localparam int UMAX = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int CW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UNW  = (UMAX > 1) ? $clog2(UMAX) : 1;
  localparam int CAW  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  state_t           state_q, state_d;
  logic [31:0]      shift_q, shift_d;
  logic [5:0]       bit_q, bit_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [UNW-1:0]   unit_q, unit_d;
  logic [CAW-1:0]   car_q, car_d;
  logic             lvl_q, lvl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             env_q, env_d;
  logic             tx_q, tx_d;
  logic             seg_end;
  logic             mark_d;

  function automatic logic is_mark(input state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

  always_ff @(posedge master_clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      unit_q  <= '0;
      car_q   <= '0;
      lvl_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      car_q   <= car_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      env_q   <= env_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    done_d  = 1'b0;
    seg_end = (cyc_q == '0) && (unit_q == '0);

    // Two-level down-counter: cycles within a unit, then units within a segment.
    if (cyc_q != '0) begin
      cyc_d = cyc_q - 1'b1;
    end else begin
      cyc_d = CW'(UNIT_CYCLES - 1);
      if (unit_q != '0) unit_d = unit_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        cyc_d  = '0;
        unit_d = '0;
        if (send) begin
          state_d = LEAD_MARK;
          shift_d = data;
          bit_d   = '0;
          cyc_d   = CW'(UNIT_CYCLES - 1);
          unit_d  = UNW'(15);
        end
      end
      LEAD_MARK: if (seg_end) begin
        state_d = LEAD_SPACE;
        unit_d  = UNW'(7);
      end
      LEAD_SPACE: if (seg_end) begin
        state_d = BIT_MARK;
        unit_d  = '0;
      end
      BIT_MARK: if (seg_end) begin
        state_d = BIT_SPACE;
        unit_d  = shift_q[0] ? UNW'(2) : '0;
      end
      BIT_SPACE: if (seg_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 6'd1;
        unit_d  = '0;
        state_d = (bit_q == 6'd31) ? STOP_MARK : BIT_MARK;
      end
      STOP_MARK: if (seg_end) begin
        state_d = GAP;
        unit_d  = UNW'(GAP_UNITS - 1);
      end
      GAP: if (seg_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Carrier phase restarts high on the first cycle of every mark.
  always_comb begin
    mark_d = is_mark(state_d);
    car_d  = '0;
    lvl_d  = 1'b0;
    if (mark_d && !is_mark(state_q)) begin
      car_d = CAW'(CARRIER_HALF - 1);
      lvl_d = 1'b1;
    end else if (mark_d) begin
      if (car_q == '0) begin
        car_d = CAW'(CARRIER_HALF - 1);
        lvl_d = ~lvl_q;
      end else begin
        car_d = car_q - 1'b1;
        lvl_d = lvl_q;
      end
    end
    busy_d = (state_d != IDLE);
    env_d  = mark_d;
    tx_d   = mark_d & lvl_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ir_envelope = env_q;
  assign ir_tx       = tx_q;

endmodule

// File: tb/tb_ir_nec_transmit.sv
// Scoreboarded bench for ir_nec_transmit: a cycle waveform model plus an
// envelope decoder checked against expected words and frame lengths.
module tb_ir_nec_transmit;
  localparam int U   = 4;
  localparam int CH  = 1;
  localparam int GAP = 4;

  logic        master_clk;
  logic        resetn;
  logic        send;
  logic [31:0] data;
  logic        busy, done, ir_envelope, ir_tx;

  ir_nec_transmit #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .GAP_UNITS(GAP)) dut (
    .master_clk (master_clk),
    .resetn     (resetn),
    .send       (send),
    .data       (data),
    .busy       (busy),
    .done       (done),
    .ir_envelope(ir_envelope),
    .ir_tx      (ir_tx)
  );

  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        tmo_flag = 1'b0;

  logic [3:0]  wave_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_len_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected {busy,done,env,tx} per cycle for one segment.
  task automatic push_seg(input bit mark, input int units);
    for (int i = 0; i < units * U; i++) begin
      logic tx_e;
      tx_e = mark && (((i / CH) % 2) == 0);
      wave_q.push_back({1'b1, 1'b0, mark, tx_e});
    end
  endtask

  task automatic push_frame(input logic [31:0] w);
    push_seg(1'b1, 16);
    push_seg(1'b0, 8);
    for (int b = 0; b < 32; b++) begin
      push_seg(1'b1, 1);
      push_seg(1'b0, w[b] ? 3 : 1);
    end
    push_seg(1'b1, 1);
    push_seg(1'b0, GAP);
    wave_q.push_back(4'b0100);
    exp_data_q.push_back(w);
    exp_len_q.push_back((89 + 2 * $countones(w) + GAP) * U);
  endtask

  // Single model/monitor process: model at posedge, compare at negedge.
  initial begin
    logic        model_idle;
    logic        rst_applied;
    logic [3:0]  obs, expv;
    logic        prev_env;
    int          low_run, busy_run, nbits;
    logic [31:0] word;
    model_idle = 1'b1;
    prev_env = 1'b0;
    low_run = 0; busy_run = 0; nbits = 0; word = '0;
    forever begin
      @(posedge master_clk);
      cyc++;
      rst_applied = !resetn;
      if (!resetn) begin
        wave_q.delete();
        exp_data_q.delete();
        exp_len_q.delete();
      end else if (send && model_idle) begin
        push_frame(data);
      end

      @(negedge master_clk);
      obs  = {busy, done, ir_envelope, ir_tx};
      expv = (wave_q.size() > 0) ? wave_q.pop_front() : 4'b0000;
      chk("wave", {28'd0, obs}, {28'd0, expv});
      chk("wait_bound", {31'd0, tmo_flag}, 32'd0);
      if (ir_tx === 1'b1 && ir_envelope !== 1'b1) chk("tx_without_env", 32'd1, 32'd0);
      model_idle = !expv[3];

      if (rst_applied) begin
        low_run = 0; busy_run = 0; nbits = 0; word = '0; prev_env = 1'b0;
      end else begin
        if (busy === 1'b1) busy_run++;
        if (ir_envelope === 1'b0 && busy === 1'b1) low_run++;
        if (ir_envelope === 1'b1) begin
          if (!prev_env && low_run > 0) begin
            if (low_run == 3 * U) begin
              word = {1'b1, word[31:1]}; nbits++;
            end else if (low_run == U) begin
              word = {1'b0, word[31:1]}; nbits++;
            end
          end
          low_run = 0;
        end
        if (done === 1'b1) begin
          if (exp_data_q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
          end else begin
            chk("decode", word, exp_data_q.pop_front());
            chk("busy_len", busy_run, exp_len_q.pop_front());
            chk("bit_count", nbits, 32'd32);
          end
          low_run = 0; busy_run = 0; nbits = 0; word = '0;
        end
        prev_env = (ir_envelope === 1'b1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge master_clk);
    #1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) tmo_flag = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send = 1'b1;
    data = w;
    tick(1);
    send = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    send   = 1'b0;
    data   = '0;
    tick(1);
    send = 1'b1;
    data = 32'hDEADBEEF;
    tick(3);
    send   = 1'b0;
    resetn = 1'b1;
    tick(6);

    send_word(32'h0000_0000);
    wait_done();
    tick(3);

    send_word(32'hFFFF_FFFF);
    wait_done();
    tick(3);

    send_word(32'hFB04_6B86);
    tick(198);
    send = 1'b1;
    data = 32'h1234_5678;
    tick(1);
    send = 1'b0;
    data = 32'h0BAD_F00D;
    wait_done();
    tick(3);

    send = 1'b1;
    data = 32'hA5A5_0F0F;
    tick(1);
    data = 32'h0000_FFFF;
    wait_done();
    wait_done();
    send = 1'b0;
    tick(4);

    send_word(32'h3C3C_C3C3);
    tick(148);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(10);
    send_word(32'h0000_00FF);
    wait_done();
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
